// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the CAM controller: FSM state encoding, lookup
// counter width and the legal range of the lookup latency parameter.
package cam_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_LKP_WAIT = 3'd3,
    ST_RESULT   = 3'd4
  } state_t;

  localparam int LKP_CNT_W          = 4;
  localparam int LOOKUP_LATENCY_MIN = 1;
  localparam int LOOKUP_LATENCY_MAX = 15;

  // Clamp the requested latency into the range the 4-bit counter can hold.
  function automatic logic [LKP_CNT_W-1:0] lookup_load(input int latency);
    int lat;
    lat = latency;
    if (lat < LOOKUP_LATENCY_MIN) lat = LOOKUP_LATENCY_MIN;
    if (lat > LOOKUP_LATENCY_MAX) lat = LOOKUP_LATENCY_MAX;
    return LKP_CNT_W'(lat);
  endfunction

endpackage

// File: rtl/cam_ctrl.sv
// Front-end controller for an external CAM: serialises entry updates and
// key lookups, one operation outstanding at a time, and presents lookup
// results on a valid/ready interface.
module cam_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int C_TCAM_ADDR_WIDTH       = 5,
  parameter int C_TCAM_DATA_WIDTH       = 32,
  parameter int C_TCAM_MATCH_ADDR_WIDTH = 5,
  parameter int C_LOOKUP_LATENCY        = 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               UPD_VALID,
  output logic                               UPD_READY,
  input  logic [C_TCAM_ADDR_WIDTH-1:0]       UPD_ADDR,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       UPD_DATA,
  input  logic                               LKP_VALID,
  output logic                               LKP_READY,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       LKP_KEY,
  output logic                               RES_VALID,
  input  logic                               RES_READY,
  output logic                               RES_HIT,
  output logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] RES_ADDR,
  output logic                               CAM_WE,
  output logic [C_TCAM_ADDR_WIDTH-1:0]       CAM_ADDR_WR,
  output logic [C_TCAM_DATA_WIDTH-1:0]       CAM_DIN,
  input  logic                               CAM_BUSY,
  output logic [C_TCAM_DATA_WIDTH-1:0]       CAM_CMP_DIN,
  input  logic                               CAM_MATCH,
  input  logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] CAM_MATCH_ADDR
);

  localparam logic [LKP_CNT_W-1:0] LAT_LOAD = lookup_load(C_LOOKUP_LATENCY);

  state_t               state;
  state_t               state_nxt;
  logic [LKP_CNT_W-1:0] lkp_cnt;
  logic                 idle_free;
  logic                 upd_fire;
  logic                 lkp_fire;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode, handshakes and CAM write strobe.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    idle_free = 1'b0;
    upd_fire  = 1'b0;
    lkp_fire  = 1'b0;
    UPD_READY = 1'b0;
    LKP_READY = 1'b0;
    CAM_WE    = 1'b0;
    RES_VALID = 1'b0;
    case (state)
      ST_IDLE: begin
        // Updates win over a simultaneous lookup; nothing is taken while the
        // CAM is still busy or while reset is held.
        idle_free = !CAM_BUSY && !RST;
        UPD_READY = idle_free;
        LKP_READY = idle_free && !UPD_VALID;
        upd_fire  = idle_free && UPD_VALID;
        lkp_fire  = idle_free && !UPD_VALID && LKP_VALID;
        if (upd_fire)      state_nxt = ST_WRITE;
        else if (lkp_fire) state_nxt = ST_LKP_WAIT;
      end
      ST_WRITE: begin
        CAM_WE    = 1'b1;
        state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!CAM_BUSY) state_nxt = ST_IDLE;
      end
      ST_LKP_WAIT: begin
        if (lkp_cnt == '0) state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        RES_VALID = 1'b1;
        if (RES_READY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, lookup latency countdown and result sampling.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lkp_cnt     <= '0;
      CAM_ADDR_WR <= '0;
      CAM_DIN     <= '0;
      CAM_CMP_DIN <= '0;
      RES_HIT     <= 1'b0;
      RES_ADDR    <= '0;
    end else begin
      if (upd_fire) begin
        CAM_ADDR_WR <= UPD_ADDR;
        CAM_DIN     <= UPD_DATA;
      end
      if (lkp_fire) begin
        // The compare key stays on the CAM until the next lookup is taken.
        CAM_CMP_DIN <= LKP_KEY;
        lkp_cnt     <= LAT_LOAD;
      end else if (state == ST_LKP_WAIT) begin
        if (lkp_cnt == '0) begin
          RES_HIT  <= CAM_MATCH;
          RES_ADDR <= CAM_MATCH ? CAM_MATCH_ADDR : '0;
        end else begin
          lkp_cnt <= lkp_cnt - LKP_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: a behavioural CAM with configurable busy
// time and a pipelined compare result, plus a reference table of written
// entries from which every expected lookup result is derived.
module tb_cam_ctrl;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int MW  = 5;
  localparam int LAT = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          UPD_VALID;
  logic          UPD_READY;
  logic [AW-1:0] UPD_ADDR;
  logic [DW-1:0] UPD_DATA;
  logic          LKP_VALID;
  logic          LKP_READY;
  logic [DW-1:0] LKP_KEY;
  logic          RES_VALID;
  logic          RES_READY;
  logic          RES_HIT;
  logic [MW-1:0] RES_ADDR;
  logic          CAM_WE;
  logic [AW-1:0] CAM_ADDR_WR;
  logic [DW-1:0] CAM_DIN;
  logic          CAM_BUSY;
  logic [DW-1:0] CAM_CMP_DIN;
  logic          CAM_MATCH;
  logic [MW-1:0] CAM_MATCH_ADDR;

  int n_tests = 0;
  int n_fail  = 0;

  cam_ctrl #(
    .C_TCAM_ADDR_WIDTH      (AW),
    .C_TCAM_DATA_WIDTH      (DW),
    .C_TCAM_MATCH_ADDR_WIDTH(MW),
    .C_LOOKUP_LATENCY       (LAT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .UPD_VALID     (UPD_VALID),
    .UPD_READY     (UPD_READY),
    .UPD_ADDR      (UPD_ADDR),
    .UPD_DATA      (UPD_DATA),
    .LKP_VALID     (LKP_VALID),
    .LKP_READY     (LKP_READY),
    .LKP_KEY       (LKP_KEY),
    .RES_VALID     (RES_VALID),
    .RES_READY     (RES_READY),
    .RES_HIT       (RES_HIT),
    .RES_ADDR      (RES_ADDR),
    .CAM_WE        (CAM_WE),
    .CAM_ADDR_WR   (CAM_ADDR_WR),
    .CAM_DIN       (CAM_DIN),
    .CAM_BUSY      (CAM_BUSY),
    .CAM_CMP_DIN   (CAM_CMP_DIN),
    .CAM_MATCH     (CAM_MATCH),
    .CAM_MATCH_ADDR(CAM_MATCH_ADDR)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural CAM ----------------
  logic [DW-1:0] cam_mem [32];
  logic [31:0]   cam_vld = '0;
  int            busy_len = 0;
  int            busy_cnt = 0;
  logic          busy_force = 1'b0;
  logic [DW-1:0] key_pipe [LAT];
  logic          cam_hit;
  logic [MW-1:0] cam_idx;

  assign CAM_BUSY       = (busy_cnt != 0) || busy_force;
  assign CAM_MATCH      = cam_hit;
  assign CAM_MATCH_ADDR = cam_idx;

  // CAM storage, write-busy timer and compare pipeline of LAT stages.
  always @(posedge CLK) begin
    if (CAM_WE) begin
      cam_mem[CAM_ADDR_WR] <= CAM_DIN;
      cam_vld[CAM_ADDR_WR] <= 1'b1;
      busy_cnt             <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    key_pipe[0] <= CAM_CMP_DIN;
    for (int i = 1; i < LAT; i++) key_pipe[i] <= key_pipe[i-1];
  end

  // Lowest matching index wins; a miss reports a junk address of 7.
  always_comb begin
    cam_hit = 1'b0;
    cam_idx = 5'd7;
    for (int i = 31; i >= 0; i--) begin
      if (cam_vld[i] && cam_mem[i] == key_pipe[LAT-1]) begin
        cam_hit = 1'b1;
        cam_idx = 5'(i);
      end
    end
  end

  // ---------------- reference table and result counter ----------------
  logic [DW-1:0] ref_mem [32];
  logic [31:0]   ref_vld = '0;
  int            res_count = 0;

  always @(posedge CLK) begin
    if (RES_VALID && RES_READY) res_count <= res_count + 1;
  end

  function automatic int ref_find(input logic [DW-1:0] key);
    for (int i = 0; i < 32; i++) begin
      if (ref_vld[i] && ref_mem[i] == key) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the cycle in which an update is being accepted.
  task automatic update_body(input logic [AW-1:0] a, input logic [DW-1:0] d, input int b);
    int n;
    int we_seen;
    int leak;
    @(negedge CLK);
    UPD_VALID = 1'b0;
    #1;
    check("we_pulse", 32'(CAM_WE), 32'd1);
    check("we_addr", 32'(CAM_ADDR_WR), 32'(a));
    check("we_data", CAM_DIN, d);
    ref_mem[a] = d;
    ref_vld[a] = 1'b1;
    n = 0;
    we_seen = 0;
    leak = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
      if (CAM_WE) we_seen++;
      if (!UPD_READY && LKP_READY) leak++;
    end while (!UPD_READY && n < 60);
    check("upd_turnaround", n, 2 + b);
    check("we_single", we_seen, 0);
    check("ready_leak_wr", leak, 0);
  endtask

  task automatic do_update(input logic [AW-1:0] a, input logic [DW-1:0] d, input int b);
    int w;
    @(negedge CLK);
    busy_len  = b;
    UPD_VALID = 1'b1;
    UPD_ADDR  = a;
    UPD_DATA  = d;
    #1;
    w = 0;
    while (!UPD_READY && w < 50) begin
      @(negedge CLK);
      #1;
      w++;
    end
    check("upd_accept", 32'(UPD_READY), 32'd1);
    update_body(a, d, b);
  endtask

  // Called at the cycle in which a lookup is being accepted.
  task automatic lookup_body(input logic [DW-1:0] key, input int hold);
    int n;
    int leak;
    int we_seen;
    int stable;
    int exp_i;
    int base;
    logic          h0;
    logic [MW-1:0] a0;
    exp_i = ref_find(key);
    base  = res_count;
    @(negedge CLK);
    LKP_VALID = 1'b0;
    #1;
    check("cmp_key", CAM_CMP_DIN, key);
    n = 0;
    leak = 0;
    we_seen = 0;
    while (!RES_VALID && n < 40) begin
      if (UPD_READY || LKP_READY) leak++;
      if (CAM_WE) we_seen++;
      @(negedge CLK);
      #1;
      n++;
    end
    check("res_latency", n, LAT + 1);
    check("res_hit", 32'(RES_HIT), (exp_i >= 0) ? 32'd1 : 32'd0);
    check("res_addr", 32'(RES_ADDR), (exp_i >= 0) ? 32'(exp_i) : 32'd0);
    h0 = RES_HIT;
    a0 = RES_ADDR;
    stable = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      #1;
      if (!RES_VALID || RES_HIT !== h0 || RES_ADDR !== a0) stable++;
      if (UPD_READY || LKP_READY) leak++;
      if (CAM_WE) we_seen++;
    end
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    #1;
    check("res_drop", 32'(RES_VALID), 32'd0);
    check("res_stable", stable, 0);
    check("ready_leak_lk", leak, 0);
    check("we_in_lookup", we_seen, 0);
    check("res_count", res_count - base, 1);
  endtask

  task automatic do_lookup(input logic [DW-1:0] key, input int hold);
    int w;
    @(negedge CLK);
    LKP_VALID = 1'b1;
    LKP_KEY   = key;
    #1;
    w = 0;
    while (!LKP_READY && w < 50) begin
      @(negedge CLK);
      #1;
      w++;
    end
    check("lkp_accept", 32'(LKP_READY), 32'd1);
    lookup_body(key, hold);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] pool [4] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h5A5A5A5A};

  initial begin
    int leak;
    int seen;
    int base;
    RST       = 1'b1;
    UPD_VALID = 1'b0;
    UPD_ADDR  = '0;
    UPD_DATA  = '0;
    LKP_VALID = 1'b0;
    LKP_KEY   = '0;
    RES_READY = 1'b0;

    // Reset state while RST is still held.
    repeat (2) @(negedge CLK);
    #1;
    check("rst_upd_ready", 32'(UPD_READY), 32'd0);
    check("rst_lkp_ready", 32'(LKP_READY), 32'd0);
    check("rst_res_valid", 32'(RES_VALID), 32'd0);
    check("rst_res_hit", 32'(RES_HIT), 32'd0);
    check("rst_res_addr", 32'(RES_ADDR), 32'd0);
    check("rst_cam_we", 32'(CAM_WE), 32'd0);
    check("rst_cam_addr", 32'(CAM_ADDR_WR), 32'd0);
    check("rst_cam_din", CAM_DIN, 32'd0);
    check("rst_cmp_din", CAM_CMP_DIN, 32'd0);
    RST = 1'b0;

    // Directed: update with 3 busy cycles, hit, miss.
    do_update(5'h1A, 32'hDEADBEEF, 3);
    do_lookup(32'hDEADBEEF, 0);
    do_lookup(32'h12345678, 0);

    // Simultaneous update and lookup: update first, lookup after WR_WAIT.
    @(negedge CLK);
    busy_len  = 2;
    UPD_VALID = 1'b1;
    UPD_ADDR  = 5'h03;
    UPD_DATA  = 32'hCAFEF00D;
    LKP_VALID = 1'b1;
    LKP_KEY   = 32'hCAFEF00D;
    #1;
    check("both_upd_ready", 32'(UPD_READY), 32'd1);
    check("both_lkp_ready", 32'(LKP_READY), 32'd0);
    update_body(5'h03, 32'hCAFEF00D, 2);
    check("lkp_after_wr", 32'(LKP_READY), 32'd1);
    lookup_body(32'hCAFEF00D, 1);

    // Back-pressured result held five cycles.
    do_lookup(32'hDEADBEEF, 5);

    // CAM busy while idle blocks acceptance until it falls.
    @(negedge CLK);
    busy_force = 1'b1;
    busy_len   = 1;
    UPD_VALID  = 1'b1;
    UPD_ADDR   = 5'h05;
    UPD_DATA   = 32'h0BADC0DE;
    LKP_VALID  = 1'b0;
    #1;
    leak = 0;
    for (int k = 0; k < 3; k++) begin
      if (UPD_READY || LKP_READY) leak++;
      @(negedge CLK);
      #1;
    end
    check("busy_block", leak, 0);
    busy_force = 1'b0;
    #1;
    check("busy_release", 32'(UPD_READY), 32'd1);
    update_body(5'h05, 32'h0BADC0DE, 1);

    // Reset one cycle after LKP_WAIT is entered discards the lookup.
    @(negedge CLK);
    LKP_VALID = 1'b1;
    LKP_KEY   = 32'hCAFEF00D;
    #1;
    check("pre_rst_accept", 32'(LKP_READY), 32'd1);
    @(negedge CLK);
    LKP_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    base = res_count;
    check("mid_rst_res_valid", 32'(RES_VALID), 32'd0);
    check("mid_rst_res_hit", 32'(RES_HIT), 32'd0);
    check("mid_rst_res_addr", 32'(RES_ADDR), 32'd0);
    check("mid_rst_cam_we", 32'(CAM_WE), 32'd0);
    check("mid_rst_cam_addr", 32'(CAM_ADDR_WR), 32'd0);
    check("mid_rst_cam_din", CAM_DIN, 32'd0);
    check("mid_rst_cmp_din", CAM_CMP_DIN, 32'd0);
    seen = 0;
    RES_READY = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      #1;
      if (RES_VALID) seen++;
    end
    RES_READY = 1'b0;
    check("rst_no_result", seen, 0);
    check("rst_no_delivery", res_count - base, 0);
    do_lookup(32'hDEADBEEF, 2);

    // Randomised mix of updates and lookups against the reference table.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_update(5'($urandom_range(0, 31)), pool[$urandom_range(0, 3)],
                  int'($urandom_range(0, 4)));
      end else if ($urandom_range(0, 3) != 0) begin
        do_lookup(pool[$urandom_range(0, 3)], int'($urandom_range(0, 3)));
      end else begin
        do_lookup($urandom, int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
